// File: rtl/kbd_fifo_ctrl.sv
// PS/2 decoder read sequencer with a show-ahead scancode FIFO for CPU polling.
// Drains the decoder autonomously and records a sticky overflow on dropped bytes.
module kbd_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_ready,
  output logic              kbd_rdn,
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [1:0]        fsm_state
);

  // Handshakes: the decoder offers a byte while kbd_ready=1 and consumes it on the
  // single low cycle of kbd_rdn; the CPU pops the head when cpu_rd=1 and cpu_valid=1.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic              rdn_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push_req, push, pop, drop, full;

  assign full     = (count == FULL_CNT);
  assign pop      = cpu_rd && cpu_valid;
  assign push_req = (state == IDLE) && kbd_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kbd_ready) state_nxt = ACK;
      ACK:     state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    rdn_nxt = (state_nxt != ACK);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      kbd_rdn <= 1'b1;
    end else begin
      state   <= state_nxt;
      kbd_rdn <= rdn_nxt;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Storage is deliberately left unreset; cpu_data masks it while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= kbd_data;
  end

  assign cpu_valid = (count != '0);
  assign cpu_data  = cpu_valid ? mem[rd_ptr] : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// Directed bench for kbd_fifo_ctrl: handshake timing, FIFO order, overflow and async reset.
module tb_kbd_fifo_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_rdn;
  logic       cpu_rd;
  logic [7:0] cpu_data;
  logic       cpu_valid;
  logic [3:0] count;
  logic       ovf;
  logic       ovf_clr;
  logic [1:0] fsm_state;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  kbd_fifo_ctrl #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .kbd_rdn   (kbd_rdn),
    .cpu_rd    (cpu_rd),
    .cpu_data  (cpu_data),
    .cpu_valid (cpu_valid),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .fsm_state (fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full decoder transaction starting from IDLE; ends at the negedge where IDLE returns.
  task automatic push_byte(input logic [7:0] d);
    kbd_data  = d;
    kbd_ready = 1'b1;
    @(negedge clk);
    kbd_ready = 1'b0;
    check("rdn_ack", kbd_rdn, 0);
    if (exp_q.size() < 8) exp_q.push_back(d);
    else                  exp_ovf = 1'b1;
    check("count_push", count, exp_q.size());
    check("ovf_push", ovf, exp_ovf);
    @(negedge clk);
    check("rdn_settle", kbd_rdn, 1);
    @(negedge clk);
  endtask

  task automatic pop_byte();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("pop_model_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("pop_valid", cpu_valid, 1);
      check("pop_data", cpu_data, e);
      cpu_rd = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0;
      check("pop_count", count, exp_q.size());
    end
  endtask

  initial begin
    clrn      = 1'b0;
    kbd_data  = 8'h00;
    kbd_ready = 1'b0;
    cpu_rd    = 1'b0;
    ovf_clr   = 1'b0;

    // 1. reset state
    repeat (3) @(negedge clk);
    check("rst_rdn_in_reset", kbd_rdn, 1);
    clrn = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_rdn", kbd_rdn, 1);
    check("rst_count", count, 0);
    check("rst_valid", cpu_valid, 0);
    check("rst_data", cpu_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", fsm_state, 0);

    // 2. single byte, 1-cycle latency, then pop
    kbd_data  = 8'h1C;
    kbd_ready = 1'b1;
    @(negedge clk);
    kbd_ready = 1'b0;
    check("t2_rdn_low", kbd_rdn, 0);
    check("t2_state_ack", fsm_state, 1);
    check("t2_valid", cpu_valid, 1);
    check("t2_data", cpu_data, 8'h1C);
    check("t2_count", count, 1);
    @(negedge clk);
    check("t2_rdn_high", kbd_rdn, 1);
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    check("t2_pop_count", count, 0);
    check("t2_pop_data", cpu_data, 0);
    check("t2_pop_valid", cpu_valid, 0);
    @(negedge clk);

    // 3. held kbd_ready, 0x01..0x09: 3-cycle strobe period, overflow on 0x09
    kbd_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      kbd_data = 8'(i);
      @(negedge clk);
      check("t3_rdn_low", kbd_rdn, 0);
      if (exp_q.size() < 8) exp_q.push_back(8'(i));
      else                  exp_ovf = 1'b1;
      check("t3_count", count, exp_q.size());
      check("t3_ovf", ovf, exp_ovf);
      @(negedge clk);
      check("t3_rdn_hi1", kbd_rdn, 1);
      @(negedge clk);
      check("t3_rdn_hi2", kbd_rdn, 1);
      if (i == 9) kbd_ready = 1'b0;
    end
    check("t3_count_sat", count, 8);
    check("t3_ovf_set", ovf, 1);
    for (int i = 0; i < 8; i++) pop_byte();
    check("t3_drained", cpu_valid, 0);
    check("t3_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check("t3_ovf_clr", ovf, 0);

    // 4. full FIFO, push and pop together
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    check("t4_full", count, 8);
    check("t4_head", cpu_data, exp_q.pop_front());
    kbd_data  = 8'h38;
    kbd_ready = 1'b1;
    cpu_rd    = 1'b1;
    @(negedge clk);
    kbd_ready = 1'b0;
    cpu_rd    = 1'b0;
    exp_q.push_back(8'h38);
    check("t4_count", count, 8);
    check("t4_ovf", ovf, 0);
    check("t4_new_head", cpu_data, 8'h31);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) pop_byte();
    check("t4_empty", count, 0);

    // 5. three interleaved fill/drain rounds across pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(r * 8 + i));
      for (int i = 0; i < 3; i++) pop_byte();
      for (int i = 5; i < 8; i++) push_byte(8'h40 + 8'(r * 8 + i));
      for (int i = 0; i < 5; i++) pop_byte();
    end
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    check("t5_empty_rd_count", count, 0);
    check("t5_empty_rd_valid", cpu_valid, 0);
    check("t5_empty_rd_data", cpu_data, 0);
    check("t5_ovf", ovf, 0);

    // 6. async reset during ACK with ovf set
    for (int i = 0; i < 9; i++) push_byte(8'h60 + 8'(i));
    check("t6_ovf_set", ovf, 1);
    kbd_data  = 8'h6A;
    kbd_ready = 1'b1;
    @(negedge clk);
    kbd_ready = 1'b0;
    check("t6_rdn_ack", kbd_rdn, 0);
    #2 clrn = 1'b0;
    #1;
    check("t6_rst_rdn", kbd_rdn, 1);
    check("t6_rst_count", count, 0);
    check("t6_rst_ovf", ovf, 0);
    check("t6_rst_valid", cpu_valid, 0);
    check("t6_rst_data", cpu_data, 0);
    check("t6_rst_state", fsm_state, 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    check("t6_idle_after", fsm_state, 0);
    push_byte(8'h77);
    check("t6_new_data", cpu_data, 8'h77);
    pop_byte();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
